// File: rtl/bus_tx_framer.sv
// Transmit framer ahead of data_bus: header byte, buffered payload, end-of-frame ack.
// Payload bytes are staged in a show-ahead FIFO that may be prefilled while idle.
module bus_tx_framer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] src_id,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_dest,
    input  logic [1:0] cmd_opcode,
    input  logic [7:0] cmd_len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       abort,
    output logic       send_valid,
    output logic [7:0] send_data,
    input  logic       send_ready,
    output logic       ack,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        ACK
    } state_t;

    state_t state;

    logic [7:0]    hdr;
    logic [7:0]    rem;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic empty;
    logic flush;
    logic xfer;
    logic push;
    logic pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign xfer  = send_valid && send_ready;

    // Abort is ignored during the ack cycle; everywhere else it empties the FIFO.
    assign flush = abort && (state != ACK);
    assign push  = in_valid && in_ready && !flush;
    assign pop   = xfer && (state == PAYLOAD) && !flush;

    assign cmd_ready = (state == IDLE);
    assign in_ready  = !full;
    assign busy      = (state != IDLE);

    always_comb begin
        send_valid = 1'b0;
        send_data  = 8'h00;
        unique case (state)
            HDR: begin
                send_valid = 1'b1;
                send_data  = hdr;
            end
            PAYLOAD: begin
                send_valid = !empty;
                send_data  = empty ? 8'h00 : mem[rd_ptr];
            end
            default: begin
                send_valid = 1'b0;
                send_data  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hdr     <= 8'h00;
            rem     <= 8'h00;
            ack     <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            ack     <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        hdr   <= {2'b00, cmd_dest, src_id, cmd_opcode};
                        rem   <= cmd_len;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (abort) begin
                        state   <= ACK;
                        ack     <= 1'b1;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (xfer) begin
                        if (rem == 8'd0) begin
                            state <= ACK;
                            ack   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (abort) begin
                        state   <= ACK;
                        ack     <= 1'b1;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (xfer) begin
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            state <= ACK;
                            ack   <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_tx_framer.sv
// Scoreboard bench for bus_tx_framer: expected bus bytes and acks are queued
// by the stimulus and consumed by a negedge monitor.
module tb_bus_tx_framer;

    logic       clk;
    logic       rst_n;
    logic [1:0] src_id;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dest;
    logic [1:0] cmd_opcode;
    logic [7:0] cmd_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       abort;
    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;
    logic       ack;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks;
    int errors;

    typedef struct {
        bit         is_ack;
        logic [7:0] data;
        bit         ab;
    } exp_t;

    exp_t sb[$];

    bus_tx_framer #(.DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_id     (src_id),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dest   (cmd_dest),
        .cmd_opcode (cmd_opcode),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .abort      (abort),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .ack        (ack),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void exp_byte(input logic [7:0] d);
        exp_t e;
        e.is_ack = 1'b0;
        e.data   = d;
        e.ab     = 1'b0;
        sb.push_back(e);
    endfunction

    function automatic void exp_ack(input bit ab);
        exp_t e;
        e.is_ack = 1'b1;
        e.data   = 8'h00;
        e.ab     = ab;
        sb.push_back(e);
    endfunction

    // Monitor: inputs change just after posedge, so the negedge view is what the next edge sees.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (send_valid && send_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL bus_byte: got %0h, expected nothing", send_data);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_ack || send_data !== e.data) begin
                            errors++;
                            $display("FAIL bus_byte: got %0h, expected %0h ack=%0d",
                                     send_data, e.data, e.is_ack);
                        end
                    end
                end
                if (ack) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL ack: got ack, expected nothing");
                    end else begin
                        e = sb.pop_front();
                        if (!e.is_ack || aborted !== e.ab || done !== 1'b1) begin
                            errors++;
                            $display("FAIL ack: got aborted=%0d done=%0d, expected ack aborted=%0d",
                                     aborted, done, e.ab);
                        end
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] s, input logic [1:0] d,
                         input logic [1:0] op, input logic [7:0] len);
        src_id     = s;
        cmd_dest   = d;
        cmd_opcode = op;
        cmd_len    = len;
        cmd_valid  = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_n);
        int n;
        n = 0;
        while (!ack && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no ack, expected ack within 200 cycles");
        end else if (exp_n >= 0) begin
            check("frame_latency", n, exp_n);
        end
        @(posedge clk);
        #1;
        check("idle_after_ack", busy, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        src_id     = 2'd0;
        cmd_valid  = 1'b0;
        cmd_dest   = 2'd0;
        cmd_opcode = 2'd0;
        cmd_len    = 8'd0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        abort      = 1'b0;
        send_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_send_valid", send_valid, 1'b0);
        check("rst_send_data", send_data, 8'h00);
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic prefilled frame: header 0x25, three bytes, ack.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        exp_byte(8'h25);
        exp_byte(8'h11);
        exp_byte(8'h22);
        exp_byte(8'h33);
        exp_ack(1'b0);
        issue(2'd1, 2'd2, 2'd1, 8'd3);
        check("hdr_next_cycle", send_data, 8'h25);
        wait_done(4);

        // Header-only frame leaves prefilled FIFO byte for later.
        push_byte(8'h44);
        exp_byte(8'h32);
        exp_ack(1'b0);
        issue(2'd0, 2'd3, 2'd2, 8'd0);
        wait_done(1);
        check("fifo_untouched", in_ready, 1'b1);

        // Stall during header.
        send_ready = 1'b0;
        exp_byte(8'h25);
        exp_byte(8'h44);
        exp_ack(1'b0);
        issue(2'd1, 2'd2, 2'd1, 8'd1);
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", send_valid, 1'b1);
            check("stall_data", send_data, 8'h25);
            @(posedge clk);
            #1;
        end
        send_ready = 1'b1;
        wait_done(-1);

        // Long frame, FIFO fills then refills slowly with bubbles.
        send_ready = 1'b0;
        exp_byte(8'h1B);
        for (int i = 0; i < 10; i++) exp_byte(8'hA0 + 8'(i));
        exp_ack(1'b0);
        issue(2'd2, 2'd1, 2'd3, 8'd10);
        for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
        check("full_in_ready", in_ready, 1'b0);
        push_byte(8'hEE);
        check("full_hold", in_ready, 1'b0);
        send_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("bubble1", {busy, send_valid}, 2'b10);
        push_byte(8'hA8);
        repeat (3) @(posedge clk);
        #1;
        check("bubble2", {busy, send_valid}, 2'b10);
        push_byte(8'hA9);
        wait_done(-1);

        // Abort after second payload byte.
        for (int i = 0; i < 5; i++) push_byte(8'h51 + 8'(i));
        exp_byte(8'h10);
        exp_byte(8'h51);
        exp_byte(8'h52);
        exp_ack(1'b1);
        issue(2'd0, 2'd1, 2'd0, 8'd5);
        repeat (3) @(posedge clk);
        #1;
        send_ready = 1'b0;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        abort      = 1'b0;
        send_ready = 1'b1;
        check("abort_ack", {ack, done, aborted}, 3'b111);
        @(posedge clk);
        #1;
        check("abort_idle", busy, 1'b0);
        exp_byte(8'h00);
        exp_byte(8'h66);
        exp_ack(1'b0);
        issue(2'd0, 2'd0, 2'd0, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        check("flushed_bubble", {busy, send_valid}, 2'b10);
        push_byte(8'h66);
        wait_done(-1);

        // Reset in the middle of the payload.
        push_byte(8'h71);
        push_byte(8'h72);
        push_byte(8'h73);
        exp_byte(8'h25);
        exp_byte(8'h71);
        issue(2'd1, 2'd2, 2'd1, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", send_valid, 1'b0);
        check("mid_rst_ack", ack, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sb", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_byte(8'h81);
        exp_byte(8'h3B);
        exp_byte(8'h81);
        exp_ack(1'b0);
        issue(2'd2, 2'd3, 2'd3, 8'd1);
        wait_done(2);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
